fft_frame_sequencer: RTL and testbench
======================================

# fft_frame_sequencer

Frame-level controller between the UART receive FIFO, the 512-point FFT core and the display RAM read by the VGA block. It waits for a full frame in the FIFO, writes the FFT configuration once after reset, streams the frame into the core and collects the output bins. It then writes either raw samples or saturated bin magnitudes into the display RAM, selected by `sw`. It replaces the loose glue logic around the FFT with one state machine that has defined timing.

## Interface
Parameters:
- `N_LOG2`, 9: log2 of the frame length (N = 512).
- `DW`, 8: sample and bin width.
- `SCALE_SCH`, 18'b000000000000010010: FFT scaling schedule.
- `TIMEOUT`, 4095: maximum number of cycles to wait for the first `fft_dv`.

Ports:
- `clk`  in  1: single clock (CLK_OUT1 domain).
- `rst_n`  in  1: asynchronous, active-low reset.
- `sw`  in  1: display mode. 1 = spectrum magnitude, 0 = raw samples.
- `fifo_count`  in  N_LOG2+1: FIFO occupancy.
- `fifo_dout`  in  DW: FIFO read data, valid 1 cycle after `fifo_rd_en`.
- `fifo_rd_en`  out  1: FIFO pop.
- `fft_ce`, `fft_start`, `fft_fwd_inv`, `fft_fwd_inv_we`, `fft_scale_sch_we`  out  1: FFT core controls.
- `fft_scale_sch`  out  18: constant `SCALE_SCH`.
- `fft_xn_re`  out  DW: equals `fifo_dout`, combinational.
- `fft_rfd`, `fft_dv`  in  1: core ready-for-data and output-valid.
- `fft_xk_index`  in  N_LOG2: output bin index.
- `fft_xk_re`, `fft_xk_im`  in  DW: output bin, signed.
- `ram_we`  out  1, `ram_addr`  out  N_LOG2, `ram_din`  out  DW: display RAM write port.
- `frame_done`  out  1: one-cycle pulse at the end of each frame.
- `timeout_err`  out  1: sticky error flag; cleared only by reset.

## Operation
States: CFG → IDLE → LOAD → WAIT_DV → UNLOAD → DONE → IDLE.
- **CFG**
  - Entered on reset release.
  - For exactly 1 cycle, `fft_fwd_inv_we=1`, `fft_scale_sch_we=1` and `fft_fwd_inv=1`.
  - Next state: IDLE.
- **IDLE**
  - Goes to LOAD when `fifo_count >= N`.
  - On entry to LOAD: `fft_start` pulses for 1 cycle and `fft_ce` rises.
- **LOAD**
  - `fifo_rd_en = fft_rfd && (ld_cnt < N)`. `ld_cnt` increments on each pop.
  - If `rfd` drops, pops stall and resume when it returns.
  - Goes to WAIT_DV once `ld_cnt == N` and the last sample has been presented (1 cycle after the last pop).
  - In raw mode, every sample popped is also written to the RAM, 1 cycle after the pop: `ram_addr = ld_cnt_prev`, `ram_din = fifo_dout`.
- **WAIT_DV**
  - `to_cnt` counts up from 0.
  - Goes to UNLOAD on the first `fft_dv`.
  - If `to_cnt == TIMEOUT`: set `timeout_err`, drop `fft_ce`, go to IDLE.
- **UNLOAD**
  - Each `fft_dv` cycle computes `mag = re*re + im*im` (signed, 16-bit unsigned result).
  - `ram_din = (mag > 255) ? 255 : mag[7:0]`, `ram_addr = xk_index`, `ram_we` registered 1 cycle after `fft_dv` (spectrum mode only).
  - Goes to DONE after the `fft_dv` with `xk_index == N-1`.
- **DONE**
  - `fft_ce` drops, `frame_done` pulses, next state is IDLE.
- `sw` is sampled once on entry to LOAD and held for the whole frame. Changing `sw` mid-frame has no effect until the next frame.

## Timing
- **Reset values:** all outputs 0 except `fft_fwd_inv=1` and `fft_scale_sch=SCALE_SCH`; state = CFG; counters = 0.
- **Reset mid-frame:** asynchronous abort with no further RAM writes. CFG re-runs after release. FIFO contents are not touched.
- **IDLE→LOAD latency:** 1 cycle after `fifo_count` reaches N. The first `fifo_rd_en` can assert in the first LOAD cycle.
- **RAM write latency:** 1 cycle after the pop (raw mode) or after `fft_dv` (spectrum mode). Exactly N writes per frame.
- `fft_dv` seen in any state other than WAIT_DV or UNLOAD is ignored.
- Frames run back to back: if `fifo_count >= N` in IDLE, LOAD starts on the next cycle.

## Structure
- Shared package `fft_seq_pkg` holds:
  - the state enum;
  - `N_LOG2`, `DW`;
  - the default `SCALE_SCH`;
  - the `MAG_SAT = 255` constant.
- One sub-module, `mag_sat`: a registered signed-square-sum-and-saturate with 1-cycle latency.

## Test plan
- **Reset then configure:** release `rst_n` → exactly one cycle with both `fft_fwd_inv_we=1` and `fft_scale_sch_we=1`, then IDLE.
- **Raw frame:** `sw=0`, FIFO filled with 0..511, `rfd` held high → 512 `fifo_rd_en` pulses, RAM[i]=i%256, one `frame_done` pulse.
- **Spectrum saturation:** `sw=1`, bin 5 = (re=16, im=0) → RAM[5]=255; bin 6 = (re=-3, im=4) → RAM[6]=25; exactly 512 RAM writes.
- **rfd stall:** drop `rfd` for 10 cycles mid-LOAD → no pops during the stall, total pops still 512, sample order preserved.
- **Timeout:** `fft_dv` never asserts → `timeout_err=1` after 4096 WAIT_DV cycles, `fft_ce=0`, returns to IDLE.
- **Reset mid-UNLOAD:** assert `rst_n=0` at bin 200 → `ram_we` goes to 0 immediately, CFG repeats after release.

Source files
------------

// File: rtl/fft_seq_pkg.sv
// Shared constants and the state encoding for the FFT frame sequencer.
package fft_seq_pkg;

  localparam int N_LOG2 = 9;
  localparam int DW = 8;
  localparam logic [17:0] SCALE_SCH = 18'b000000000000010010;
  localparam int MAG_SAT = 255;

  typedef enum logic [2:0] {
    S_CFG     = 3'd0,
    S_IDLE    = 3'd1,
    S_LOAD    = 3'd2,
    S_WAIT_DV = 3'd3,
    S_UNLOAD  = 3'd4,
    S_DONE    = 3'd5
  } state_e;

endpackage

// File: rtl/fft_frame_sequencer_if.sv
// Signal bundle between the frame sequencer (master) and the FFT core (slave).
interface fft_frame_sequencer_if #(
  parameter int N_LOG2 = 9,
  parameter int DW = 8
) ();

  logic                     fft_ce;
  logic                     fft_start;
  logic                     fft_fwd_inv;
  logic                     fft_fwd_inv_we;
  logic                     fft_scale_sch_we;
  logic [17:0]              fft_scale_sch;
  logic [DW-1:0]            fft_xn_re;
  logic                     fft_rfd;
  logic                     fft_dv;
  logic [N_LOG2-1:0]        fft_xk_index;
  logic signed [DW-1:0]     fft_xk_re;
  logic signed [DW-1:0]     fft_xk_im;

  modport master (
    output fft_ce, fft_start, fft_fwd_inv, fft_fwd_inv_we, fft_scale_sch_we,
    output fft_scale_sch, fft_xn_re,
    input  fft_rfd, fft_dv, fft_xk_index, fft_xk_re, fft_xk_im
  );

  modport slave (
    input  fft_ce, fft_start, fft_fwd_inv, fft_fwd_inv_we, fft_scale_sch_we,
    input  fft_scale_sch, fft_xn_re,
    output fft_rfd, fft_dv, fft_xk_index, fft_xk_re, fft_xk_im
  );

endinterface

// File: rtl/fft_frame_sequencer_mag_sat.sv
// Registered |X|^2 = re^2 + im^2 of one FFT bin, saturated to the display width.
module mag_sat #(
  parameter int DW = 8,
  parameter int IW = 9
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 vld_i,
  input  logic signed [DW-1:0] re_i,
  input  logic signed [DW-1:0] im_i,
  input  logic [IW-1:0]        idx_i,
  output logic                 vld_o,
  output logic [DW-1:0]        mag_o,
  output logic [IW-1:0]        idx_o
);
  import fft_seq_pkg::*;

  // One spare bit so (-2^(DW-1))^2 * 2 never overflows the signed sum.
  localparam int PW = 2 * DW + 1;

  function automatic logic [DW-1:0] sat_mag(input logic [PW-1:0] m);
    if (m > PW'(MAG_SAT)) return DW'(MAG_SAT);
    return m[DW-1:0];
  endfunction

  logic signed [PW-1:0] re_x, im_x, sum;
  logic                 vld_q;
  logic [DW-1:0]        mag_q;
  logic [IW-1:0]        idx_q;

  // Sign-extend both components and form the square sum.
  always_comb begin
    re_x = {{(PW-DW){re_i[DW-1]}}, re_i};
    im_x = {{(PW-DW){im_i[DW-1]}}, im_i};
    sum  = re_x * re_x + im_x * im_x;
  end

  // Valid is control and clears on reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) vld_q <= 1'b0;
    else        vld_q <= vld_i;
  end

  // ---- stage boundary: saturated magnitude and its bin index ----
  always_ff @(posedge clk) begin
    mag_q <= sat_mag(unsigned'(sum));
    idx_q <= idx_i;
  end

  assign vld_o = vld_q;
  assign mag_o = mag_q;
  assign idx_o = idx_q;

endmodule

// File: rtl/fft_frame_sequencer.sv
// Frame controller: FIFO -> FFT core -> display RAM (raw samples or bin magnitudes).
module fft_frame_sequencer #(
  parameter int          N_LOG2    = fft_seq_pkg::N_LOG2,
  parameter int          DW        = fft_seq_pkg::DW,
  parameter logic [17:0] SCALE_SCH = fft_seq_pkg::SCALE_SCH,
  parameter int          TIMEOUT   = 4095
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  sw,
  input  logic [N_LOG2:0]       fifo_count,
  input  logic [DW-1:0]         fifo_dout,
  output logic                  fifo_rd_en,
  fft_frame_sequencer_if.master fft,
  output logic                  ram_we,
  output logic [N_LOG2-1:0]     ram_addr,
  output logic [DW-1:0]         ram_din,
  output logic                  frame_done,
  output logic                  timeout_err
);
  import fft_seq_pkg::*;

  localparam int                N        = 1 << N_LOG2;
  localparam int                TO_W     = $clog2(TIMEOUT + 1);
  localparam logic [N_LOG2:0]   N_CNT    = (N_LOG2+1)'(N);
  localparam logic [N_LOG2-1:0] LAST_IDX = N_LOG2'(N - 1);
  localparam logic [TO_W-1:0]   TO_MAX   = TO_W'(TIMEOUT);

  state_e              state_q, state_d;
  logic                run_q, start_q, pop_q, mode_q, err_q;
  logic [N_LOG2:0]     ld_cnt_q;
  logic [N_LOG2-1:0]   ld_prev_q;
  logic [TO_W-1:0]     to_cnt_q;
  logic                go_load, to_fire, mag_in_vld, mag_vld;
  logic [DW-1:0]       mag_val;
  logic [N_LOG2-1:0]   mag_idx;

  assign go_load = (state_q == S_IDLE) && (state_d == S_LOAD);
  assign to_fire = (state_q == S_WAIT_DV) && (state_d == S_IDLE);

  assign fft.fft_fwd_inv   = 1'b1;
  assign fft.fft_scale_sch = SCALE_SCH;
  assign fft.fft_xn_re     = fifo_dout;
  assign fft.fft_start     = start_q;
  assign timeout_err       = err_q;

  // State register; CFG is re-entered on every reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_CFG;
    else        state_q <= state_d;
  end

  // Next-state logic; fft_dv wins over a coincident timeout.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_CFG:     if (run_q) state_d = S_IDLE;
      S_IDLE:    if (fifo_count >= N_CNT) state_d = S_LOAD;
      S_LOAD:    if (ld_cnt_q == N_CNT) state_d = S_WAIT_DV;
      S_WAIT_DV: begin
        if (fft.fft_dv)              state_d = S_UNLOAD;
        else if (to_cnt_q == TO_MAX) state_d = S_IDLE;
      end
      S_UNLOAD:  if (fft.fft_dv && (fft.fft_xk_index == LAST_IDX)) state_d = S_DONE;
      S_DONE:    state_d = S_IDLE;
      default:   state_d = S_CFG;
    endcase
  end

  // Outputs decoded from state plus the RAM write-port mux.
  always_comb begin
    fft.fft_ce           = (state_q == S_LOAD) || (state_q == S_WAIT_DV) || (state_q == S_UNLOAD);
    fft.fft_fwd_inv_we   = (state_q == S_CFG) && run_q;
    fft.fft_scale_sch_we = (state_q == S_CFG) && run_q;
    fifo_rd_en           = (state_q == S_LOAD) && fft.fft_rfd && (ld_cnt_q < N_CNT);
    frame_done           = (state_q == S_DONE);
    mag_in_vld           = fft.fft_dv && ((state_q == S_WAIT_DV) || (state_q == S_UNLOAD));
    ram_we               = 1'b0;
    ram_addr             = '0;
    ram_din              = '0;
    if (!mode_q && pop_q) begin
      ram_we   = 1'b1;
      ram_addr = ld_prev_q;
      ram_din  = fifo_dout;
    end else if (mode_q && mag_vld) begin
      ram_we   = 1'b1;
      ram_addr = mag_idx;
      ram_din  = mag_val;
    end
  end

  // Control registers: counters, pulses, frame mode and the sticky error.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      run_q    <= 1'b0;
      start_q  <= 1'b0;
      pop_q    <= 1'b0;
      mode_q   <= 1'b0;
      err_q    <= 1'b0;
      ld_cnt_q <= '0;
      to_cnt_q <= '0;
    end else begin
      run_q    <= 1'b1;
      start_q  <= go_load;
      pop_q    <= fifo_rd_en;
      to_cnt_q <= (state_q == S_WAIT_DV) ? to_cnt_q + TO_W'(1) : '0;
      if (go_load) begin
        ld_cnt_q <= '0;
        mode_q   <= sw;
      end else if (fifo_rd_en) begin
        ld_cnt_q <= ld_cnt_q + (N_LOG2+1)'(1);
      end
      if (to_fire) err_q <= 1'b1;
    end
  end

  // ---- stage boundary: address of the sample popped last cycle ----
  always_ff @(posedge clk) begin
    if (fifo_rd_en) ld_prev_q <= ld_cnt_q[N_LOG2-1:0];
  end

  mag_sat #(.DW(DW), .IW(N_LOG2)) u_mag_sat (
    .clk   (clk),
    .rst_n (rst_n),
    .vld_i (mag_in_vld),
    .re_i  (fft.fft_xk_re),
    .im_i  (fft.fft_xk_im),
    .idx_i (fft.fft_xk_index),
    .vld_o (mag_vld),
    .mag_o (mag_val),
    .idx_o (mag_idx)
  );

endmodule

// File: tb/tb_fft_frame_sequencer.sv
// Directed bench for fft_frame_sequencer with FIFO, FFT-core and RAM models.
`timescale 1ns/1ps
module tb_fft_frame_sequencer;

  localparam int          NL  = 9;
  localparam int          W   = 8;
  localparam int          NN  = 512;
  localparam logic [17:0] SCH = 18'b000000000000010010;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          sw = 1'b0;
  logic [NL:0]   fifo_count;
  logic [W-1:0]  fifo_dout = '0;
  logic          fifo_rd_en;
  logic          ram_we;
  logic [NL-1:0] ram_addr;
  logic [W-1:0]  ram_din;
  logic          frame_done;
  logic          timeout_err;

  fft_frame_sequencer_if #(.N_LOG2(NL), .DW(W)) fft ();

  fft_frame_sequencer #(.N_LOG2(NL), .DW(W), .SCALE_SCH(SCH), .TIMEOUT(4095)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .sw          (sw),
    .fifo_count  (fifo_count),
    .fifo_dout   (fifo_dout),
    .fifo_rd_en  (fifo_rd_en),
    .fft         (fft),
    .ram_we      (ram_we),
    .ram_addr    (ram_addr),
    .ram_din     (ram_din),
    .frame_done  (frame_done),
    .timeout_err (timeout_err)
  );

  always #5 clk = ~clk;

  // FIFO model: data valid one cycle after the pop.
  logic [W-1:0] fifo_mem [0:2047];
  int wr_ptr = 0;
  int rd_ptr = 0;
  assign fifo_count = (NL+1)'(wr_ptr - rd_ptr);
  always @(posedge clk) begin
    if (fifo_rd_en) begin
      fifo_dout <= fifo_mem[rd_ptr % 2048];
      rd_ptr    <= rd_ptr + 1;
    end
  end

  // Display RAM model with write and frame_done counters.
  logic [W-1:0] ram [0:NN-1];
  int wr_total = 0;
  int done_total = 0;
  always @(posedge clk) begin
    if (ram_we) begin
      ram[ram_addr] <= ram_din;
      wr_total      <= wr_total + 1;
    end
    if (frame_done) done_total <= done_total + 1;
  end

  typedef struct { int idx; int re; int im; int exp; } vec_t;
  vec_t vt [11];

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic fill(input int fmode);
    for (int i = 0; i < NN; i++)
      fifo_mem[(wr_ptr + i) % 2048] = (fmode == 0) ? W'(i) : W'(i * 7 + 3);
    wr_ptr = wr_ptr + NN;
  endtask

  task automatic bin_val(input int k, output int re, output int im);
    re = 2;
    im = 1;
    for (int i = 0; i < 11; i++)
      if (vt[i].idx == k) begin
        re = vt[i].re;
        im = vt[i].im;
      end
  endtask

  task automatic cfg_check(input string tag);
    int n_cfg = 0;
    int n_split = 0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (6) begin
      @(negedge clk);
      if (fft.fft_fwd_inv_we && fft.fft_scale_sch_we) n_cfg++;
      if (fft.fft_fwd_inv_we != fft.fft_scale_sch_we) n_split++;
    end
    chk({tag, "_cfg_pulses"}, n_cfg, 1);
    chk({tag, "_cfg_we_pair"}, n_split, 0);
  endtask

  // Push a frame and check the IDLE->LOAD handover.
  task automatic start_frame(input int fmode, input logic swv);
    @(posedge clk); #1;
    sw = swv;
    fill(fmode);
    @(negedge clk);
    chk("idle_no_pop", fifo_rd_en, 0);
    @(negedge clk);
    chk("load_start", fft.fft_start, 1);
    chk("load_rd_en", fifo_rd_en, 1);
    chk("load_ce", fft.fft_ce, 1);
    @(negedge clk);
    chk("start_pulse_1cyc", fft.fft_start, 0);
  endtask

  task automatic wait_pops(input int target);
    int n = 0;
    while (rd_ptr < target && n < 3000) begin
      @(negedge clk);
      n++;
    end
    chk("pop_wait_bound", int'(rd_ptr >= target), 1);
  endtask

  // Present bins 0..511 back to back; returns early (dv still high) at stop_at.
  task automatic drive_bins(input int stop_at);
    int re, im;
    @(posedge clk);
    @(posedge clk); #1;
    for (int k = 0; k < NN; k++) begin
      if (k == stop_at) return;
      bin_val(k, re, im);
      fft.fft_dv       = 1'b1;
      fft.fft_xk_index = NL'(k);
      fft.fft_xk_re    = W'(re);
      fft.fft_xk_im    = W'(im);
      @(posedge clk); #1;
    end
    fft.fft_dv = 1'b0;
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int pb, wb, db, mism, n;
    vt[0]  = '{5, 16, 0, 255};
    vt[1]  = '{6, -3, 4, 25};
    vt[2]  = '{0, 0, 0, 0};
    vt[3]  = '{7, 15, 5, 250};
    vt[4]  = '{8, -128, -128, 255};
    vt[5]  = '{9, 11, 11, 242};
    vt[6]  = '{10, -16, 0, 255};
    vt[7]  = '{100, 12, -12, 255};
    vt[8]  = '{101, -15, -2, 229};
    vt[9]  = '{300, 2, 1, 5};
    vt[10] = '{511, 1, -1, 2};

    fft.fft_rfd = 1'b1;
    fft.fft_dv = 1'b0;
    fft.fft_xk_index = '0;
    fft.fft_xk_re = '0;
    fft.fft_xk_im = '0;

    // Reset values
    repeat (3) @(negedge clk);
    chk("rst_fwd_inv", fft.fft_fwd_inv, 1);
    chk("rst_scale_sch", fft.fft_scale_sch, SCH);
    chk("rst_cfg_we", fft.fft_fwd_inv_we | fft.fft_scale_sch_we, 0);
    chk("rst_ce_start", fft.fft_ce | fft.fft_start, 0);
    chk("rst_rd_en", fifo_rd_en, 0);
    chk("rst_ram_we", ram_we, 0);
    chk("rst_done_err", frame_done | timeout_err, 0);
    cfg_check("boot");

    // Raw frame 0..511
    pb = rd_ptr; wb = wr_total; db = done_total;
    start_frame(0, 1'b0);
    wait_pops(pb + NN);
    drive_bins(NN);
    repeat (5) @(negedge clk);
    chk("raw_pops", rd_ptr - pb, NN);
    chk("raw_writes", wr_total - wb, NN);
    chk("raw_done", done_total - db, 1);
    chk("raw_ce_off", fft.fft_ce, 0);
    mism = 0;
    for (int i = 0; i < NN; i++) if (ram[i] !== W'(i)) mism++;
    chk("raw_ram_mism", mism, 0);
    chk("raw_ram_511", ram[511], 255);

    // Spectrum frame; sw flips mid-load and must be ignored
    pb = rd_ptr; wb = wr_total; db = done_total;
    start_frame(0, 1'b1);
    wait_pops(pb + 100);
    sw = 1'b0;
    wait_pops(pb + NN);
    chk("spec_load_writes", wr_total - wb, 0);
    drive_bins(NN);
    repeat (5) @(negedge clk);
    chk("spec_writes", wr_total - wb, NN);
    chk("spec_done", done_total - db, 1);
    for (int i = 0; i < 11; i++) chk($sformatf("spec_bin_%0d", vt[i].idx), ram[vt[i].idx], vt[i].exp);

    // Raw frame with a 10-cycle rfd stall
    pb = rd_ptr; wb = wr_total; db = done_total;
    start_frame(1, 1'b0);
    wait_pops(pb + 200);
    fft.fft_rfd = 1'b0;
    n = rd_ptr;
    repeat (10) @(negedge clk);
    chk("stall_no_pop", rd_ptr - n, 0);
    fft.fft_rfd = 1'b1;
    wait_pops(pb + NN);
    drive_bins(NN);
    repeat (5) @(negedge clk);
    chk("stall_pops", rd_ptr - pb, NN);
    chk("stall_writes", wr_total - wb, NN);
    chk("stall_done", done_total - db, 1);
    mism = 0;
    for (int i = 0; i < NN; i++) if (ram[i] !== W'(i * 7 + 3)) mism++;
    chk("stall_order_mism", mism, 0);

    // Timeout: no fft_dv at all
    pb = rd_ptr; wb = wr_total; db = done_total;
    start_frame(0, 1'b1);
    wait_pops(pb + NN);
    n = 0;
    repeat (50) begin @(negedge clk); n++; end
    chk("wait_ce_on", fft.fft_ce, 1);
    chk("wait_err_clear", timeout_err, 0);
    while (!timeout_err && n < 6000) begin @(negedge clk); n++; end
    chk("timeout_cycles", n, 4097);
    chk("timeout_err_set", timeout_err, 1);
    chk("timeout_ce_off", fft.fft_ce, 0);
    // dv in IDLE must not produce writes or a frame end
    @(posedge clk); #1;
    fft.fft_dv = 1'b1;
    fft.fft_xk_index = '1;
    fft.fft_xk_re = 8'sd16;
    repeat (5) @(posedge clk);
    #1 fft.fft_dv = 1'b0;
    repeat (3) @(negedge clk);
    chk("idle_dv_writes", wr_total - wb, 0);
    chk("idle_dv_done", done_total - db, 0);
    chk("err_sticky", timeout_err, 1);

    // Reset in the middle of UNLOAD (bin 200)
    pb = rd_ptr; wb = wr_total;
    start_frame(0, 1'b1);
    wait_pops(pb + NN);
    drive_bins(201);
    chk("pre_abort_writes", wr_total - wb, 200);
    chk("pre_abort_we", ram_we, 1);
    rst_n = 1'b0;
    #1;
    chk("abort_we_now", ram_we, 0);
    chk("abort_ce_err", fft.fft_ce | timeout_err, 0);
    fft.fft_dv = 1'b0;
    wb = wr_total;
    repeat (3) @(negedge clk);
    chk("abort_no_writes", wr_total - wb, 0);
    cfg_check("rerun");
    chk("rerun_idle_no_pop", fifo_rd_en, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
